// File: rtl/nibble_serial_add_ctrl.sv
// nibble_serial_add_ctrl
// Sequences a W-bit add through one shared combinational 4-bit adder slice,
// one nibble per clock, LSB nibble first, and registers the final result.
//
// Handshake: start is sampled only in IDLE; the accepting edge latches
// op_a/op_b/cin. busy is high for the NIBBLES RUN cycles. done pulses for
// exactly one cycle (DONE state) when sum/cout/ovf have just been updated.
// start seen in RUN or DONE is dropped, never queued.
module nibble_serial_add_ctrl #(
   parameter int NIBBLES = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic [4*NIBBLES-1:0]   op_a,
   input  logic [4*NIBBLES-1:0]   op_b,
   input  logic                   cin,
   output logic                   busy,
   output logic                   done,
   output logic [4*NIBBLES-1:0]   sum,
   output logic                   cout,
   output logic                   ovf,
   output logic [3:0]             add_a,
   output logic [3:0]             add_b,
   output logic                   add_cin,
   input  logic [3:0]             add_y,
   input  logic                   add_c,
   output logic [1:0]             dbg_state
);

   localparam int W = 4 * NIBBLES;
   localparam logic [2:0] LAST_IDX = 3'(NIBBLES - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t         r_state;
   state_t         w_next_state;
   logic [2:0]     r_idx;
   logic           r_carry;
   logic [W-1:0]   r_a;
   logic [W-1:0]   r_b;
   logic [W-1:0]   r_work;
   logic [W-1:0]   r_sum;
   logic           r_cout;
   logic           r_ovf;

   logic           w_last;
   logic [3:0]     w_nib_a;
   logic [3:0]     w_nib_b;
   logic [W-1:0]   w_work_next;
   logic           w_ovf;

   assign w_last    = (r_idx == LAST_IDX);
   assign sum       = r_sum;
   assign cout      = r_cout;
   assign ovf       = r_ovf;
   assign dbg_state = r_state;

   // Select the current operand nibbles and merge the slice result into the work word.
   always_comb begin
      w_nib_a     = 4'd0;
      w_nib_b     = 4'd0;
      w_work_next = r_work;
      for (int i = 0; i < NIBBLES; i++) begin
         if (r_idx == 3'(i)) begin
            w_nib_a                = r_a[4*i +: 4];
            w_nib_b                = r_b[4*i +: 4];
            w_work_next[4*i +: 4]  = add_y;
         end
      end
      w_ovf = (r_a[W-1] == r_b[W-1]) && (w_work_next[W-1] != r_a[W-1]);
   end

   // Next-state logic and Moore-style handshake/adder-drive outputs.
   always_comb begin
      w_next_state = r_state;
      busy         = 1'b0;
      done         = 1'b0;
      add_a        = 4'd0;
      add_b        = 4'd0;
      add_cin      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_next_state = S_RUN;
            end
         end
         S_RUN: begin
            busy    = 1'b1;
            add_a   = w_nib_a;
            add_b   = w_nib_b;
            add_cin = r_carry;
            if (w_last) begin
               w_next_state = S_DONE;
            end
         end
         S_DONE: begin
            done         = 1'b1;
            w_next_state = S_IDLE;
         end
         default: begin
            w_next_state = S_IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Operand capture, nibble stepping, carry ripple and result registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_idx   <= 3'd0;
         r_carry <= 1'b0;
         r_a     <= '0;
         r_b     <= '0;
         r_work  <= '0;
         r_sum   <= '0;
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_a     <= op_a;
                  r_b     <= op_b;
                  r_carry <= cin;
                  r_idx   <= 3'd0;
               end
            end
            S_RUN: begin
               r_work  <= w_work_next;
               r_carry <= add_c;
               if (w_last) begin
                  // Final nibble comes straight from the slice this cycle.
                  r_sum  <= w_work_next;
                  r_cout <= add_c;
                  r_ovf  <= w_ovf;
               end else begin
                  r_idx <= r_idx + 3'd1;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Bench for nibble_serial_add_ctrl (NIBBLES=4) with a behavioural adder slice.
module tb_nibble_serial_add_ctrl;

   localparam int NIB = 4;
   localparam int W   = 4 * NIB;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic [W-1:0]  op_a;
   logic [W-1:0]  op_b;
   logic          cin;
   logic          busy;
   logic          done;
   logic [W-1:0]  sum;
   logic          cout;
   logic          ovf;
   logic [3:0]    add_a;
   logic [3:0]    add_b;
   logic          add_cin;
   logic [3:0]    add_y;
   logic          add_c;
   logic [1:0]    dbg_state;

   int            n_checks = 0;
   int            n_fail   = 0;
   logic [W+1:0]  exp_q[$];          // {ovf, cout, sum}
   logic [W-1:0]  last_sum = '0;

   nibble_serial_add_ctrl #(.NIBBLES(NIB)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .op_a      (op_a),
      .op_b      (op_b),
      .cin       (cin),
      .busy      (busy),
      .done      (done),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf),
      .add_a     (add_a),
      .add_b     (add_b),
      .add_cin   (add_cin),
      .add_y     (add_y),
      .add_c     (add_c),
      .dbg_state (dbg_state)
   );

   // Behavioural 4-bit adder slice.
   assign {add_c, add_y} = {1'b0, add_a} + {1'b0, add_b} + {4'd0, add_cin};

   // Clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic c);
      logic [W:0]   full;
      logic         v;
      full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
      v    = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
      return {v, full};
   endfunction

   // Scoreboard: every done pulse must match the oldest expected result.
   always @(negedge clk) begin
      logic [W+1:0] e;
      if (done === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            check("sum",  32'(sum),  32'(e[W-1:0]));
            check("cout", 32'(cout), 32'(e[W]));
            check("ovf",  32'(ovf),  32'(e[W+1]));
            last_sum = e[W-1:0];
         end
      end
   end

   // One operation with a one-cycle start; records the slice drive per RUN cycle.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                         output logic [15:0] a_seq, output logic [3:0] cin_seq,
                         output int busy_cnt);
      @(negedge clk);
      op_a  = a;
      op_b  = b;
      cin   = c;
      start = 1'b1;
      exp_q.push_back(model(a, b, c));
      @(negedge clk);
      start    = 1'b0;
      op_a     = W'($urandom_range(0, 16'hFFFF));
      op_b     = W'($urandom_range(0, 16'hFFFF));
      busy_cnt = 0;
      a_seq    = '0;
      cin_seq  = '0;
      for (int i = 0; i < NIB; i++) begin
         a_seq[4*i +: 4] = add_a;
         cin_seq[i]      = add_cin;
         if (busy === 1'b1) busy_cnt++;
         check("sum_hold", 32'(sum), 32'(last_sum));
         check("run_no_done", 32'(done), 32'd0);
         @(negedge clk);
      end
      check("done_pulse", 32'(done), 32'd1);
      check("done_busy_low", 32'(busy), 32'd0);
      @(negedge clk);
      check("done_one_cycle", 32'(done), 32'd0);
   endtask

   initial begin
      logic [15:0] a_seq;
      logic [3:0]  cin_seq;
      int          bcnt;
      int          d[2];
      int          n_done;

      rst_n = 1'b0;
      start = 1'b0;
      op_a  = '0;
      op_b  = '0;
      cin   = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_busy",  32'(busy),  32'd0);
      check("rst_done",  32'(done),  32'd0);
      check("rst_sum",   32'(sum),   32'd0);
      check("rst_cout",  32'(cout),  32'd0);
      check("rst_ovf",   32'(ovf),   32'd0);
      check("rst_add_a", 32'(add_a), 32'd0);
      check("rst_add_cin", 32'(add_cin), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Basic add, LSB nibble first.
      run_op(16'h1234, 16'h4321, 1'b0, a_seq, cin_seq, bcnt);
      check("t1_busy_cycles", 32'(bcnt), 32'd4);
      check("t1_add_a_seq", 32'(a_seq), 32'h1234);

      // Carry ripples through every nibble; sum must hold 0x5555 throughout.
      run_op(16'hFFFF, 16'h0001, 1'b0, a_seq, cin_seq, bcnt);
      check("t2_add_cin_seq", 32'(cin_seq), 32'b1110);

      // Signed overflow, then carry-in only.
      run_op(16'h7FFF, 16'h0001, 1'b0, a_seq, cin_seq, bcnt);
      run_op(16'h0000, 16'h0000, 1'b1, a_seq, cin_seq, bcnt);
      check("t3_add_cin_first", 32'(cin_seq[0]), 32'd1);

      // A few random operations.
      for (int k = 0; k < 4; k++) begin
         run_op(W'($urandom_range(0, 16'hFFFF)), W'($urandom_range(0, 16'hFFFF)),
                1'($urandom_range(0, 1)), a_seq, cin_seq, bcnt);
         check("rand_busy_cycles", 32'(bcnt), 32'd4);
      end

      // start held high; operands change after acceptance.
      @(negedge clk);
      op_a  = 16'h1234;
      op_b  = 16'h4321;
      cin   = 1'b0;
      start = 1'b1;
      exp_q.push_back(model(16'h1234, 16'h4321, 1'b0));
      exp_q.push_back(model(16'h1111, 16'h4321, 1'b0));
      n_done = 0;
      d[0]   = 0;
      d[1]   = 0;
      for (int c = 1; c <= 40 && n_done < 2; c++) begin
         @(negedge clk);
         if (c == 1) op_a = 16'h1111;
         if (n_done == 1 && c == d[0] + 1) check("no_reaccept_in_done", 32'(busy), 32'd0);
         if (done === 1'b1) begin
            d[n_done] = c;
            n_done++;
         end
      end
      start = 1'b0;
      if (n_done < 2) begin
         check("held_start_timeout", 32'(n_done), 32'd2);
      end else begin
         check("first_done_latency", 32'(d[0]), 32'd5);
         check("done_period", 32'(d[1] - d[0]), 32'd6);
      end
      @(negedge clk);

      // Reset during the 2nd RUN cycle aborts the operation.
      op_a  = 16'h1234;
      op_b  = 16'h4321;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      check("abort_in_run", 32'(busy), 32'd1);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n    = 1'b1;
      last_sum = '0;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_sum",  32'(sum),  32'd0);
      check("abort_cout", 32'(cout), 32'd0);
      repeat (6) begin
         @(negedge clk);
         check("abort_no_done", 32'(done), 32'd0);
      end

      // Normal operation after the abort.
      run_op(16'h0F0F, 16'h00F1, 1'b0, a_seq, cin_seq, bcnt);
      check("post_abort_busy_cycles", 32'(bcnt), 32'd4);

      repeat (3) @(negedge clk);
      check("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
